// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
//   state_t        : two-state run/halt FSM encoding
//   DEF_RESET_VEC  : default PC after reset
//   DEF_EXC_VEC    : default PC on interrupt entry
package pc_gen_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0800;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidate generator.
//   pc       in  : current PC
//   imm      in  : branch immediate (signed word offset)
//   jfield   in  : J-format word-index target field
//   a        in  : register operand for JR
//   pcc      out : pc + 4 (wraps)
//   br       out : pcc + sext(imm) * 4
//   j        out : pcc upper bits spliced with jfield * 4
//   jr       out : a with the byte offset cleared
//   misalign out : a is not word aligned
module pc_target_calc #(
  parameter int XLEN    = 32,
  parameter int JADDR_W = 26,
  parameter int IMM_W   = 16
) (
  input  logic [XLEN-1:0]    pc,
  input  logic [IMM_W-1:0]   imm,
  input  logic [JADDR_W-1:0] jfield,
  input  logic [XLEN-1:0]    a,
  output logic [XLEN-1:0]    pcc,
  output logic [XLEN-1:0]    br,
  output logic [XLEN-1:0]    j,
  output logic [XLEN-1:0]    jr,
  output logic               misalign
);

  logic [XLEN-1:0] br_off;

  assign pcc      = pc + XLEN'(4);
  // Word offset sign-extended and scaled to bytes.
  assign br_off   = {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  assign br       = pcc + br_off;
  // J keeps the region bits of the delay-slot address.
  assign j        = {pcc[XLEN-1:JADDR_W+2], jfield, 2'b00};
  assign jr       = {a[XLEN-1:2], 2'b00};
  assign misalign = |a[1:0];

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator for the fetch stage.
// Holds PC, EPC, interrupt enable and a pending-interrupt latch; selects the
// next PC from sequential/branch/J/JR/ERET/exception sources by fixed priority.
//   in_clk, in_rst   : clock, synchronous active-high reset
//   in_stall         : hold everything except the interrupt latch
//   in_halt          : enter HALTED after advancing past this instruction
//   in_branch_taken, in_j, in_jr, in_eret : control-flow requests
//   in_irq           : level interrupt request (latched into irq_pend)
//   in_is, in_a      : instruction word, register operand for JR
//   out_pc, out_pcc  : fetch address, fetch address + 4
//   out_epc, out_ie  : saved exception PC, interrupt enable
//   out_halted       : FSM is HALTED
//   out_redirect     : the PC just loaded was non-sequential
//   out_misalign     : last taken JR had a non-word-aligned operand
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int             XLEN      = 32,
  parameter int             JADDR_W   = 26,
  parameter int             IMM_W     = 16,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC)
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_stall,
  input  logic            in_halt,
  input  logic            in_branch_taken,
  input  logic            in_j,
  input  logic            in_jr,
  input  logic            in_eret,
  input  logic            in_irq,
  input  logic [XLEN-1:0] in_is,
  input  logic [XLEN-1:0] in_a,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcc,
  output logic [XLEN-1:0] out_epc,
  output logic            out_ie,
  output logic            out_halted,
  output logic            out_redirect,
  output logic            out_misalign
);

  state_t          state;
  logic            irq_pend;
  logic [XLEN-1:0] br_pc, j_pc, jr_pc;
  logic            jr_mis;
  logic [XLEN-1:0] seq_pc;
  logic            seq_redir;
  logic            irq_take;
  logic            unused_is;

  // Only the immediate / jump-field bits of the instruction are used here.
  assign unused_is = ^in_is;

  pc_target_calc #(
    .XLEN   (XLEN),
    .JADDR_W(JADDR_W),
    .IMM_W  (IMM_W)
  ) u_tgt (
    .pc      (out_pc),
    .imm     (in_is[IMM_W-1:0]),
    .jfield  (in_is[JADDR_W-1:0]),
    .a       (in_a),
    .pcc     (out_pcc),
    .br      (br_pc),
    .j       (j_pc),
    .jr      (jr_pc),
    .misalign(jr_mis)
  );

  // Non-interrupt next PC; also the EPC value when an interrupt pre-empts it.
  always_comb begin
    seq_pc    = out_pcc;
    seq_redir = 1'b1;
    if (in_eret)              seq_pc = out_epc;
    else if (in_jr)           seq_pc = jr_pc;
    else if (in_j)            seq_pc = j_pc;
    else if (in_branch_taken) seq_pc = br_pc;
    else                      seq_redir = 1'b0;
  end

  // Interrupt entry happens on any unstalled RUN cycle or any HALTED cycle.
  assign irq_take = irq_pend & out_ie & ((state == ST_HALTED) | ~in_stall);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state        <= ST_RUN;
      out_pc       <= RESET_VEC;
      out_epc      <= '0;
      out_ie       <= 1'b1;
      irq_pend     <= 1'b0;
      out_redirect <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      // A request arriving in the entry cycle stays latched for later.
      irq_pend <= (irq_pend & ~irq_take) | in_irq;

      if (state == ST_HALTED) begin
        if (irq_take) begin
          out_epc      <= out_pc;
          out_pc       <= EXC_VEC;
          out_ie       <= 1'b0;
          out_redirect <= 1'b1;
          state        <= ST_RUN;
        end else begin
          out_redirect <= 1'b0;
        end
      end else if (in_stall) begin
        out_redirect <= 1'b0;
      end else if (irq_take) begin
        out_epc      <= seq_pc;
        out_pc       <= EXC_VEC;
        out_ie       <= 1'b0;
        out_redirect <= 1'b1;
      end else if (in_halt) begin
        out_pc       <= out_pcc;
        out_redirect <= 1'b0;
        state        <= ST_HALTED;
      end else begin
        out_pc       <= seq_pc;
        out_redirect <= seq_redir;
        if (in_eret) out_ie <= 1'b1;
        if (in_jr && !in_eret) out_misalign <= jr_mis;
      end
    end
  end

  assign out_halted = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by a random
// phase, every cycle compared against an arithmetic reference model.
module tb_pc_gen;

  localparam logic [31:0] EXC = 32'h0000_0800;

  logic        in_clk = 1'b0;
  logic        in_rst, in_stall, in_halt, in_branch_taken, in_j, in_jr, in_eret, in_irq;
  logic [31:0] in_is, in_a;
  logic [31:0] out_pc, out_pcc, out_epc;
  logic        out_ie, out_halted, out_redirect, out_misalign;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_epc;
  bit          m_ie, m_halted, m_pend, m_redir, m_mis;

  pc_gen dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_stall(in_stall), .in_halt(in_halt),
    .in_branch_taken(in_branch_taken), .in_j(in_j), .in_jr(in_jr),
    .in_eret(in_eret), .in_irq(in_irq), .in_is(in_is), .in_a(in_a),
    .out_pc(out_pc), .out_pcc(out_pcc), .out_epc(out_epc), .out_ie(out_ie),
    .out_halted(out_halted), .out_redirect(out_redirect), .out_misalign(out_misalign)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_rst = 0; in_stall = 0; in_halt = 0; in_branch_taken = 0;
    in_j = 0; in_jr = 0; in_eret = 0; in_irq = 0; in_is = '0; in_a = '0;
  endtask

  // Advance the reference by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0]        pcc, br, jt, jrt, nxt;
    logic signed [15:0] off;
    bit                 nred, entry;
    if (in_rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ie = 1; m_halted = 0;
      m_pend = 0; m_redir = 0; m_mis = 0;
      return;
    end
    pcc = m_pc + 32'd4;
    off = in_is[15:0];
    br  = pcc + 32'(int'(off) * 4);
    jt  = (pcc & 32'hF000_0000) | ((in_is & 32'h03FF_FFFF) * 4);
    jrt = in_a & ~32'h3;
    entry = m_pend && m_ie && (m_halted || !in_stall);
    if (m_halted) begin
      if (entry) begin
        m_epc = m_pc; m_pc = EXC; m_ie = 0; m_halted = 0; m_redir = 1;
      end else m_redir = 0;
    end else if (in_stall) begin
      m_redir = 0;
    end else begin
      nred = 1;
      if (in_eret)              nxt = m_epc;
      else if (in_jr)           nxt = jrt;
      else if (in_j)            nxt = jt;
      else if (in_branch_taken) nxt = br;
      else begin nxt = pcc; nred = 0; end
      if (entry) begin
        m_epc = nxt; m_pc = EXC; m_ie = 0; m_redir = 1;
      end else if (in_halt) begin
        m_pc = pcc; m_halted = 1; m_redir = 0;
      end else begin
        m_pc = nxt; m_redir = nred;
        if (in_eret) m_ie = 1;
        else if (in_jr) m_mis = (in_a % 4) != 0;
      end
    end
    m_pend = (m_pend && !entry) || in_irq;
  endtask

  task automatic tick();
    model_step();
    @(posedge in_clk);
    #1;
    chk("pc",       out_pc,       m_pc);
    chk("pcc",      out_pcc,      m_pc + 32'd4);
    chk("epc",      out_epc,      m_epc);
    chk("ie",       32'(out_ie),       32'(m_ie));
    chk("halted",   32'(out_halted),   32'(m_halted));
    chk("redirect", 32'(out_redirect), 32'(m_redir));
    chk("misalign", 32'(out_misalign), 32'(m_mis));
  endtask

  task automatic go_jr(input logic [31:0] a);
    idle(); in_jr = 1; in_a = a; tick(); idle();
  endtask

  initial begin
    idle();
    m_pc = '0; m_epc = '0; m_ie = 1; m_halted = 0; m_pend = 0; m_redir = 0; m_mis = 0;

    // 1: reset then sequential fetch
    in_rst = 1; tick(); tick(); idle();
    chk("t1_rst_pc", out_pc, 32'h0);
    chk("t1_rst_ie", 32'(out_ie), 32'h1);
    tick(); chk("t1_pc4", out_pc, 32'h4);
    tick(); chk("t1_pc8", out_pc, 32'h8);
    tick(); chk("t1_pcc", out_pc, 32'hC);
    chk("t1_redir", 32'(out_redirect), 32'h0);

    // 2: branches backward and forward
    go_jr(32'h100);
    in_branch_taken = 1; in_is = 32'h0000_FFFE; tick(); idle();
    chk("t2_br_back", out_pc, 32'h0FC);
    chk("t2_redir1", 32'(out_redirect), 32'h1);
    tick(); chk("t2_redir0", 32'(out_redirect), 32'h0);
    go_jr(32'h100);
    in_branch_taken = 1; in_is = 32'h0000_0003; tick(); idle();
    chk("t2_br_fwd", out_pc, 32'h110);

    // 3: J region splice, misaligned JR
    go_jr(32'hF000_0010);
    in_j = 1; in_is = 32'h0000_0040; tick(); idle();
    chk("t3_j", out_pc, 32'hF000_0100);
    go_jr(32'h1003);
    chk("t3_jr", out_pc, 32'h1000);
    chk("t3_mis", 32'(out_misalign), 32'h1);

    // 4: irq latched during stall, entry pre-empts branch, eret returns
    go_jr(32'h200);
    in_stall = 1; in_irq = 1; tick();
    in_irq = 0; tick(); chk("t4_stall", out_pc, 32'h200);
    idle(); in_branch_taken = 1; in_is = 32'h0000_003F; tick(); idle();
    chk("t4_epc", out_epc, 32'h300);
    chk("t4_pc",  out_pc,  32'h800);
    chk("t4_ie",  32'(out_ie), 32'h0);
    in_eret = 1; tick(); idle();
    chk("t4_eret", out_pc, 32'h300);
    chk("t4_ie1", 32'(out_ie), 32'h1);

    // 5: halt, ignore stall/branch, wake on irq
    go_jr(32'h40);
    in_halt = 1; tick(); idle();
    chk("t5_pc", out_pc, 32'h44);
    chk("t5_halt", 32'(out_halted), 32'h1);
    for (int i = 0; i < 5; i++) begin
      in_stall = i[0]; in_branch_taken = 1; in_is = 32'h10; tick();
    end
    idle();
    chk("t5_hold", out_pc, 32'h44);
    in_irq = 1; tick(); idle(); tick();
    chk("t5_epc", out_epc, 32'h44);
    chk("t5_exc", out_pc, 32'h800);
    chk("t5_run", 32'(out_halted), 32'h0);

    // 6: reset while halted with irq pending (ie=0 from step 5)
    in_halt = 1; tick(); idle();
    in_irq = 1; tick(); idle();
    chk("t6_halted", 32'(out_halted), 32'h1);
    in_rst = 1; tick(); idle();
    chk("t6_pc", out_pc, 32'h0);
    chk("t6_halt0", 32'(out_halted), 32'h0);
    chk("t6_epc", out_epc, 32'h0);
    tick(); tick();
    chk("t6_nopend", out_pc, 32'h8);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      in_rst          = ($urandom_range(199) == 0);
      in_stall        = ($urandom_range(4) == 0);
      in_halt         = ($urandom_range(39) == 0);
      in_branch_taken = ($urandom_range(5) == 0);
      in_j            = ($urandom_range(9) == 0);
      in_jr           = ($urandom_range(9) == 0);
      in_eret         = ($urandom_range(19) == 0);
      in_irq          = ($urandom_range(29) == 0);
      in_is           = $urandom;
      in_a            = $urandom;
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
